// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared definitions for the Wishbone core bus arbiter: FSM state
//            encodings, master indices and the fixed M0 (instruction master)
//            field values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_BUSY_M0 = 2'd1;
  localparam logic [1:0] ARB_BUSY_M1 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ARB_IDLE,
    ST_BUSY_M0 = ARB_BUSY_M0,
    ST_BUSY_M1 = ARB_BUSY_M1
  } arb_state_t;

  // Master indices as stored in the grant / last_grant registers
  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  // The instruction master is read-only and always fetches whole words
  localparam logic M0_WE      = 1'b0;
  localparam logic M0_SEL_BIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_timeout
// Purpose  : Bus-cycle watchdog. Counts enabled cycles since the last clear
//            and flags expiry on the TIMEOUT-th enabled cycle. TIMEOUT = 0
//            removes the counter and ties expire low.
// Ports    : clk    - clock
//            rst_n  - synchronous active-low reset
//            clr    - clear the count (held while the arbiter is idle)
//            en     - count this cycle (busy with no slave response)
//            expire - combinational: en is high and the count is TIMEOUT-1
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expire = 1'b0;
    end else begin : g_counter
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] count;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en) begin
          count <= count + 1'b1;
        end
      end

      // Fires only on a cycle without ack/err, so a late ack always wins
      assign expire = en && (count == LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_core_bus_arbiter
// Purpose  : Shares one Wishbone classic single-beat slave port between the
//            core's instruction master (M0, read-only) and data master (M1).
//            Registered grant, fixed data-priority or round-robin, and a
//            watchdog that terminates stalled cycles with an error.
// Ports    : wb_clk_i, wb_rst_n_i      - clock, synchronous active-low reset
//            m0_wb_*                   - instruction master (adr/cyc/stb in,
//                                        dat/ack/err out)
//            m1_wb_*                   - data master (adr/dat/we/sel/cyc/stb
//                                        in, dat/ack/err out)
//            s_wb_*                    - shared slave port
//            busy_o                    - a master currently owns the slave
// Revision : 1.0 - initial release
// ============================================================================
module wb_core_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DPORT_PRIO = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic [ADDR_W-1:0]   m0_wb_adr_i,
  input  logic                m0_wb_cyc_i,
  input  logic                m0_wb_stb_i,
  output logic [DATA_W-1:0]   m0_wb_dat_o,
  output logic                m0_wb_ack_o,
  output logic                m0_wb_err_o,
  input  logic [ADDR_W-1:0]   m1_wb_adr_i,
  input  logic [DATA_W-1:0]   m1_wb_dat_i,
  input  logic                m1_wb_we_i,
  input  logic [DATA_W/8-1:0] m1_wb_sel_i,
  input  logic                m1_wb_cyc_i,
  input  logic                m1_wb_stb_i,
  output logic [DATA_W-1:0]   m1_wb_dat_o,
  output logic                m1_wb_ack_o,
  output logic                m1_wb_err_o,
  output logic [ADDR_W-1:0]   s_wb_adr_o,
  output logic [DATA_W-1:0]   s_wb_dat_o,
  output logic                s_wb_we_o,
  output logic [DATA_W/8-1:0] s_wb_sel_o,
  output logic                s_wb_cyc_o,
  output logic                s_wb_stb_o,
  input  logic [DATA_W-1:0]   s_wb_dat_i,
  input  logic                s_wb_ack_i,
  input  logic                s_wb_err_i,
  output logic                busy_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_t state;
  logic       grant;
  logic       last_grant;

  logic req0, req1, pick;
  logic busy_m0, busy_m1, busy;
  logic g_cyc, g_stb;
  logic slave_resp, expire, release_now;

  assign req0    = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1    = m1_wb_cyc_i & m1_wb_stb_i;
  assign busy_m0 = (state == ST_BUSY_M0);
  assign busy_m1 = (state == ST_BUSY_M1);
  assign busy    = busy_m0 | busy_m1;

  assign g_cyc      = busy_m1 ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign g_stb      = busy_m1 ? m1_wb_stb_i : m0_wb_stb_i;
  assign slave_resp = s_wb_ack_i | s_wb_err_i;

  // Winner of the IDLE arbitration; only meaningful when someone requests
  always_comb begin
    pick = MST_I;
    if (req0 && req1) begin
      if (DPORT_PRIO != 0) begin
        pick = MST_D;
      end else begin
        pick = (last_grant == MST_D) ? MST_I : MST_D;
      end
    end else if (req1) begin
      pick = MST_D;
    end
  end

  // Counter is held clear while idle, so it starts from zero on BUSY entry
  wb_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .clr    (~busy),
    .en     (busy & ~slave_resp),
    .expire (expire)
  );

  // An abort (granted master drops cyc) also ends the tenure
  assign release_now = slave_resp | expire | ~g_cyc;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state      <= ST_IDLE;
      grant      <= MST_I;
      last_grant <= MST_D;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant <= pick;
            state <= (pick == MST_D) ? ST_BUSY_M1 : ST_BUSY_M0;
          end
        end
        ST_BUSY_M0, ST_BUSY_M1: begin
          if (release_now) begin
            state      <= ST_IDLE;
            last_grant <= grant;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slave side: cyc/stb only while busy, and dropped in the watchdog cycle
  assign s_wb_cyc_o = busy & g_cyc & ~expire;
  assign s_wb_stb_o = busy & g_stb & ~expire;
  assign s_wb_adr_o = (grant == MST_D) ? m1_wb_adr_i : m0_wb_adr_i;
  assign s_wb_dat_o = (grant == MST_D) ? m1_wb_dat_i : '0;
  assign s_wb_sel_o = busy_m1 ? m1_wb_sel_i :
                      busy_m0 ? {SEL_W{M0_SEL_BIT}} : '0;
  assign s_wb_we_o  = s_wb_cyc_o & (busy_m1 ? m1_wb_we_i : M0_WE);

  // Master side: read data fans out, responses go to the owner only
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = busy_m0 & s_wb_ack_i;
  assign m1_wb_ack_o = busy_m1 & s_wb_ack_i;
  assign m0_wb_err_o = busy_m0 & (s_wb_err_i | expire);
  assign m1_wb_err_o = busy_m1 & (s_wb_err_i | expire);

  assign busy_o = busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_core_bus_arbiter
// Purpose  : Self-checking bench. Two arbiters share all inputs: u_pr uses
//            data priority, u_rr uses round-robin, both with an 8-cycle
//            watchdog. Every cycle both are compared with a transaction-level
//            reference model; directed steps add targeted checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_core_bus_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_adr = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
  logic        m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = '0;
  logic        s_ack = 0, s_err = 0;

  logic [31:0] s_adr_p, s_dato_p, m0_dat_p, m1_dat_p;
  logic [31:0] s_adr_r, s_dato_r, m0_dat_r, m1_dat_r;
  logic [3:0]  s_sel_p, s_sel_r;
  logic s_we_p, s_cyc_p, s_stb_p, m0_ack_p, m0_err_p, m1_ack_p, m1_err_p, busy_p;
  logic s_we_r, s_cyc_r, s_stb_r, m0_ack_r, m0_err_r, m1_ack_r, m1_err_r, busy_r;

  wb_core_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DPORT_PRIO(1), .TIMEOUT(TO)) u_pr (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb),
    .m0_wb_dat_o(m0_dat_p), .m0_wb_ack_o(m0_ack_p), .m0_wb_err_o(m0_err_p),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_we_i(m1_we),
    .m1_wb_sel_i(m1_sel), .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb),
    .m1_wb_dat_o(m1_dat_p), .m1_wb_ack_o(m1_ack_p), .m1_wb_err_o(m1_err_p),
    .s_wb_adr_o(s_adr_p), .s_wb_dat_o(s_dato_p), .s_wb_we_o(s_we_p),
    .s_wb_sel_o(s_sel_p), .s_wb_cyc_o(s_cyc_p), .s_wb_stb_o(s_stb_p),
    .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .busy_o(busy_p)
  );

  wb_core_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DPORT_PRIO(0), .TIMEOUT(TO)) u_rr (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb),
    .m0_wb_dat_o(m0_dat_r), .m0_wb_ack_o(m0_ack_r), .m0_wb_err_o(m0_err_r),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_we_i(m1_we),
    .m1_wb_sel_i(m1_sel), .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb),
    .m1_wb_dat_o(m1_dat_r), .m1_wb_ack_o(m1_ack_r), .m1_wb_err_o(m1_err_r),
    .s_wb_adr_o(s_adr_r), .s_wb_dat_o(s_dato_r), .s_wb_we_o(s_we_r),
    .s_wb_sel_o(s_sel_r), .s_wb_cyc_o(s_cyc_r), .s_wb_stb_o(s_stb_r),
    .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .busy_o(busy_r)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner (0 none, 1 M0, 2 M1), last owner, cycles owned
  int own[2]  = '{0, 0};
  int last[2] = '{2, 2};
  int age[2]  = '{0, 0};
  int prio[2] = '{1, 0};

  task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [139:0] obs_vec(input int k);
    if (k == 0)
      return {s_adr_p, s_dato_p, s_we_p, s_sel_p, s_cyc_p, s_stb_p,
              m0_dat_p, m0_ack_p, m0_err_p, m1_dat_p, m1_ack_p, m1_err_p, busy_p};
    return {s_adr_r, s_dato_r, s_we_r, s_sel_r, s_cyc_r, s_stb_r,
            m0_dat_r, m0_ack_r, m0_err_r, m1_dat_r, m1_ack_r, m1_err_r, busy_r};
  endfunction

  // Compare both arbiters with the model mid-cycle, then advance the model
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [139:0] e, m;
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      logic mc, ms, to, cyc, stb, we, a0, e0, a1, e1, bsy;
      int w;
      adr = '0; dat = '0; sel = '0; mc = 0; ms = 0; to = 0;
      cyc = 0; stb = 0; we = 0; a0 = 0; e0 = 0; a1 = 0; e1 = 0; bsy = 0;
      if (own[k] != 0) begin
        mc  = (own[k] == 1) ? m0_cyc : m1_cyc;
        ms  = (own[k] == 1) ? m0_stb : m1_stb;
        to  = (age[k] == TO - 1) && !s_ack && !s_err;
        cyc = mc && !to;
        stb = ms && !to;
        we  = (own[k] == 2) && m1_we && cyc;
        sel = (own[k] == 2) ? m1_sel : 4'hF;
        adr = (own[k] == 2) ? m1_adr : m0_adr;
        dat = (own[k] == 2) ? m1_dat : 32'h0;
        a0  = (own[k] == 1) && s_ack;
        e0  = (own[k] == 1) && (s_err || to);
        a1  = (own[k] == 2) && s_ack;
        e1  = (own[k] == 2) && (s_err || to);
        bsy = 1;
      end
      e = {adr, dat, we, sel, cyc, stb, s_dat, a0, e0, s_dat, a1, e1, bsy};
      // Address/data/sel are only defined while a master owns the bus
      m = (own[k] == 0) ? {64'h0, 1'b1, 4'h0, {71{1'b1}}} : {140{1'b1}};
      chk((k == 0) ? "prio_cycle" : "rr_cycle", obs_vec(k) & m, e & m);

      if (!rst_n) begin
        own[k] = 0; last[k] = 2; age[k] = 0;
      end else if (own[k] == 0) begin
        age[k] = 0;
        if ((m0_cyc && m0_stb) || (m1_cyc && m1_stb)) begin
          if (m0_cyc && m0_stb && m1_cyc && m1_stb)
            w = (prio[k] != 0) ? 2 : ((last[k] == 2) ? 1 : 2);
          else
            w = (m1_cyc && m1_stb) ? 2 : 1;
          own[k] = w;
        end
      end else if (s_ack || s_err || to || !mc) begin
        last[k] = own[k];
        own[k]  = 0;
      end else begin
        age[k]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    step();
    tick();
  endtask

  initial begin
    int got[$];
    logic [31:0] exp_order[4];

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset state
    step();
    chk("rst_ctrl", {s_cyc_p, s_stb_p, s_we_p, busy_p, m0_ack_p, m0_err_p, m1_ack_p, m1_err_p,
                     s_cyc_r, s_stb_r, s_we_r, busy_r, m0_ack_r, m0_err_r, m1_ack_r, m1_err_r}, '0);
    chk("rst_fields", {s_adr_p, s_dato_p, s_sel_p, s_adr_r, s_dato_r, s_sel_r}, '0);
    tick();

    // Single M0 read, slave acks two cycles after cyc
    m0_adr = 32'h0000_0100; m0_cyc = 1; m0_stb = 1;
    step(); chk("m0_latency", s_cyc_p, 1'b0); tick();
    step();
    chk("m0_cyc", {s_cyc_p, s_adr_p, s_sel_p, s_we_p}, {1'b1, 32'h100, 4'hF, 1'b0});
    tick();
    cycle();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    step();
    chk("m0_ack", {m0_ack_p, m0_dat_p, m1_ack_p, m0_ack_r}, {1'b1, 32'hDEADBEEF, 1'b0, 1'b1});
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    cycle();

    // Simultaneous requests, data priority
    m0_adr = 32'h300; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'h2000; m1_dat = 32'h12345678; m1_we = 1; m1_sel = 4'hF; m1_cyc = 1; m1_stb = 1;
    cycle();
    s_ack = 1;
    step();
    chk("prio_m1_first", {s_cyc_p, s_we_p, s_adr_p, s_dato_p, s_sel_p, m1_ack_p, m0_ack_p},
        {1'b1, 1'b1, 32'h2000, 32'h12345678, 4'hF, 1'b1, 1'b0});
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    step(); chk("prio_gap", {s_cyc_p, busy_p}, 2'b00); tick();
    s_ack = 1;
    step();
    chk("prio_m0_second", {s_cyc_p, s_adr_p, m0_ack_p, s_we_p}, {1'b1, 32'h300, 1'b1, 1'b0});
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    cycle();

    // Watchdog: M1 read never acknowledged
    m1_adr = 32'h4000; m1_we = 0; m1_cyc = 1; m1_stb = 1;
    cycle();
    for (int i = 1; i <= TO; i++) begin
      step();
      if (i < TO) chk("wd_wait", {s_cyc_p, m1_err_p}, 2'b10);
      else chk("wd_fire", {s_cyc_p, s_stb_p, m1_err_p, m1_err_r, busy_p}, 5'b00111);
      tick();
    end
    m1_cyc = 0; m1_stb = 0;
    step(); chk("wd_idle", {busy_p, busy_r}, 2'b00); tick();
    m0_adr = 32'h500; m0_cyc = 1; m0_stb = 1;
    cycle();
    s_ack = 1;
    step(); chk("wd_then_m0", {m0_ack_p, m0_err_p, s_cyc_p}, 3'b101); tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    cycle();

    // Spurious response while idle
    s_ack = 1; s_err = 1;
    step();
    chk("spurious", {m0_ack_p, m0_err_p, m1_ack_p, m1_err_p, m0_ack_r, m0_err_r, m1_ack_r, m1_err_r}, '0);
    tick();
    s_ack = 0; s_err = 0;

    // Ack arriving in the timeout cycle wins
    m1_cyc = 1; m1_stb = 1;
    cycle();
    repeat (TO - 1) cycle();
    s_ack = 1;
    step(); chk("ack_at_timeout", {m1_ack_p, m1_err_p, m1_ack_r, m1_err_r}, 4'b1010); tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    cycle();

    // Reset in the middle of an M1 write
    m1_adr = 32'h6000; m1_we = 1; m1_cyc = 1; m1_stb = 1;
    cycle();
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1; m1_cyc = 0; m1_stb = 0; m1_we = 0; m0_adr = 32'h0;
    step();
    chk("rst_mid", {s_cyc_p, s_stb_p, s_we_p, busy_p, m1_ack_p, m1_err_p, s_sel_p, s_adr_p,
                    s_cyc_r, busy_r, m1_ack_r}, '0);
    tick();

    // Round-robin with both masters requesting continuously
    m0_adr = 32'h100; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'h200; m1_cyc = 1; m1_stb = 1;
    s_ack = 1;
    repeat (8) begin
      step();
      if (s_cyc_r) got.push_back(int'(s_adr_r));
      tick();
    end
    exp_order[0] = 32'h100; exp_order[1] = 32'h200;
    exp_order[2] = 32'h100; exp_order[3] = 32'h200;
    chk("rr_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, exp_order[i]);
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    cycle();

    // Randomised traffic checked against the model every cycle
    repeat (1500) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      m0_cyc = ($urandom_range(0, 3) != 0);
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_cyc = ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m1_we  = 1'($urandom_range(0, 1));
      m1_sel = 4'($urandom_range(0, 15));
      m0_adr = $urandom; m1_adr = $urandom; m1_dat = $urandom; s_dat = $urandom;
      s_ack  = ($urandom_range(0, 9) < 3);
      s_err  = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
